serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_fa_cell.sv | 13 +
 rtl/serial_adder.sv | 141 ++++++++++++++
 tb/tb_serial_adder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder used once per cycle by the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, one bit per clock, LSB first.
// Optional subtract mode via macro SERIAL_ADDER_SUB_EN (adds port sub).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_cat;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + ~cin, folded in at latch time.
    assign b_in   = sub ? ~b : b;
    assign cin_in = sub ? ~cin : cin;
`else
    assign b_in   = b;
    assign cin_in = cin;
`endif

    fa_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // The newest bit enters at the top; on the last cycle this is the full sum.
    assign res_cat = {fa_s, res_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_in;
                    carry_d = cin_in;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                res_d   = res_cat[WIDTH-1:1];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_cat;
                    cout_d  = fa_co;
                    ovf_d   = carry_q ^ fa_co;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8); subtract vectors need SERIAL_ADDER_SUB_EN.
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       cin_i;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub_i;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   n;

    serial_adder #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a_i),
        .b        (b_i),
        .cin      (cin_i),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub_i),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] s, input logic c, input logic o);
        exp_t x;
        x.sum  = s;
        x.cout = c;
        x.ovf  = o;
        exp_q.push_back(x);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        chk("done_timeout", done, 1);
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                          input logic [7:0] es, input logic ec, input logic eo);
        push(es, ec, eo);
        a_i   = av;
        b_i   = bv;
        cin_i = ci;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        tick();
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=done_pulse required=none sum=%0h t=%0t", sum, $time);
            end else begin
                e = exp_q.pop_front();
                chk("sum", sum, e.sum);
                chk("cout", cout, e.cout);
                chk("overflow", overflow, e.ovf);
                chk("busy_in_done", busy, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        cin_i = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub_i = 1'b0;
`endif
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        tick();

        // Basic add with busy-length measurement
        push(8'h10, 1'b0, 1'b0);
        a_i = 8'h0F; b_i = 8'h01; cin_i = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("busy_len", n, 8);
        chk("done_after_busy", done, 1);
        tick();
        chk("idle_after_done", {busy, done}, 0);

        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);

        // start held through SHIFT, operand change mid-flight ignored
        push(8'h30, 1'b0, 1'b0);
        a_i = 8'h10; b_i = 8'h20; cin_i = 1'b0; start = 1'b1;
        tick();
        tick();
        tick();
        a_i = 8'hAA;
        repeat (3) tick();
        start = 1'b0;
        wait_done();
        repeat (4) tick();
        chk("held_start_idle", busy, 0);

        // Back-to-back: start in the DONE cycle
        push(8'h10, 1'b0, 1'b0);
        a_i = 8'h0F; b_i = 8'h01; cin_i = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        push(8'h04, 1'b0, 1'b0);
        a_i = 8'h01; b_i = 8'h02; cin_i = 1'b1; start = 1'b1;
        tick();
        n = 1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("b2b_latency", n, 9);
        tick();

        // Reset abort in SHIFT cycle 4
        a_i = 8'h55; b_i = 8'h11; cin_i = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_done", done, 0);
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("abort_idle", busy, 0);
        run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub_i = 1'b1;
        run_op(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
        run_op(8'h07, 8'h05, 1'b0, 8'h02, 1'b1, 1'b0);
        sub_i = 1'b0;
`endif

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
